pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload carried per stage.
REQ-002 Parameter CLR_ON_FLUSH, default 1; when 1, flush also zeroes the data registers, and when 0, flush clears valid bits only.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst, input, 1, reset, asynchronous, active-high.
REQ-005 Port in_valid, input, 1, upstream payload valid.
REQ-006 Port in_ready, output, 1, stage can accept a payload this cycle.
REQ-007 Port in_data, input, DATA_W, upstream payload.
REQ-008 Port out_valid, output, 1, out_data holds a valid payload.
REQ-009 Port out_ready, input, 1, downstream accepts the payload this cycle.
REQ-010 Port out_data, output, DATA_W, payload presented downstream, driven directly from the main register.
REQ-011 Port flush, input, 1, synchronous discard of all held payloads.
REQ-012 Port count, output, 2, number of payloads held (0..2).

Function
REQ-013 The stage SHALL hold a main register (out_data/out_valid) and one skid register (skid_data/skid_valid); occupancy states are EMPTY (0), ONE (main only) and FULL (main+skid).
REQ-014 Input transfer SHALL occur iff in_valid & in_ready at a rising edge; output transfer iff out_valid & out_ready.
REQ-015 in_ready SHALL equal ~skid_valid & ~rst, decoded only from the skid valid flop and rst, with no combinational path from out_ready or in_valid.
REQ-016 EMPTY state: on input transfer, main <- in_data and next state is ONE; otherwise hold.
REQ-017 ONE state: on input and output transfer, main <- in_data and stay in ONE; on input transfer only, skid <- in_data and go to FULL; on output transfer only, go to EMPTY; otherwise hold.
REQ-018 FULL state: no input transfer is possible; on output transfer, main <- skid and go to ONE; otherwise hold.
REQ-019 Payload order SHALL be strictly FIFO; no payload is duplicated or dropped except by flush or reset.
REQ-020 Latency SHALL be one cycle from input transfer to out_valid in EMPTY; throughput SHALL be one payload per cycle while out_ready is held high.
REQ-021 flush SHALL take priority over all transfers in the same cycle: both valids clear, the next state is EMPTY, and a simultaneous in_data is discarded.
REQ-022 With CLR_ON_FLUSH=1, flush SHALL also zero the main and skid data; with CLR_ON_FLUSH=0, data registers hold their value.
REQ-023 count SHALL be 0/1/2 for EMPTY/ONE/FULL, registered alongside the valids.
REQ-024 Data registers SHALL load only on the transfers above; idle cycles SHALL NOT change out_data.

Reset
REQ-025 While rst=1, independent of clk: out_valid=0, skid_valid=0, out_data=0, skid_data=0, count=0, in_ready=0.
REQ-026 On the first rising edge after rst deasserts, in_ready=1 and the state is EMPTY.
REQ-027 Assertion of rst mid-transfer SHALL discard all held payloads without requiring flush.

Verification
REQ-028 Reset, then in_data=0x11 with in_valid=1 and out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0x11, count=1.
REQ-029 Stream 0x1..0x8 back-to-back with out_ready=1 throughout -> out_data emits 0x1..0x8 on consecutive cycles, in_ready stays 1, count never exceeds 1.
REQ-030 Hold out_ready=0 and push 0xA then 0xB -> count=2, in_ready=0, and 0xC is held off; release out_ready -> 0xA, 0xB, 0xC emitted in order.
REQ-031 In FULL with 0xA/0xB, assert flush together with in_valid=1 and in_data=0xD -> next cycle out_valid=0, count=0, in_ready=1, out_data=0 (CLR_ON_FLUSH=1); repeat with CLR_ON_FLUSH=0 -> out_data stays 0xA.
REQ-032 Assert rst asynchronously between edges while in FULL -> out_valid, count and in_ready drop to 0 immediately; after release, the first push 0x5 appears alone.
REQ-033 Apply random in_valid/out_ready for 10k cycles at DATA_W=8 and DATA_W=64 -> the scoreboard confirms FIFO order, zero loss and zero duplication.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid stage that fully decouples in_ready from out_ready.
// out_data comes straight from the main register; in_ready depends only on the skid-valid flop and rst.
module pipe_skid_reg #(
  parameter int DATA_W       = 32,
  parameter bit CLR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_main_valid;
  logic              r_skid_valid;
  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid_in;
  logic w_clr_data;

  function automatic logic [1:0] occupancy(input state_t st);
    case (st)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  endfunction

  assign in_ready   = ~r_skid_valid & ~rst;
  assign out_valid  = r_main_valid;
  assign out_data   = r_main_data;
  assign count      = r_count;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_main_valid & out_ready;

  // State register: valids and count are registered copies of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_main_valid <= (w_state_nxt != ST_EMPTY);
      r_skid_valid <= (w_state_nxt == ST_FULL);
      r_count      <= occupancy(w_state_nxt);
    end
  end

  // Next-state decode; flush overrides any transfer in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = ST_FULL;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_out_xfer) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Datapath load enables
  always_comb begin
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid_in   = 1'b0;
    w_clr_data     = flush & CLR_ON_FLUSH;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: w_ld_main_in = w_in_xfer;
        ST_ONE: begin
          w_ld_main_in = w_in_xfer & w_out_xfer;
          w_ld_skid_in = w_in_xfer & ~w_out_xfer;
        end
        ST_FULL:  w_ld_main_skid = w_out_xfer;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else if (w_clr_data) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_ld_main_in)        r_main_data <= in_data;
      else if (w_ld_main_skid) r_main_data <= r_skid_data;
      if (w_ld_skid_in)        r_skid_data <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, hand sequences for flush/async reset,
// and a randomized run against a queue-based reference model at 8- and 64-bit widths.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  logic        o64_ir, o64_v;
  logic [63:0] o64_d;
  logic [1:0]  o64_c;
  logic        o8_ir, o8_v;
  logic [7:0]  o8_d;
  logic [1:0]  o8_c;
  logic        on_ir, on_v;
  logic [7:0]  on_d;
  logic [1:0]  on_c;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(64), .CLR_ON_FLUSH(1'b1)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o64_ir), .in_data(in_data),
    .out_valid(o64_v), .out_ready(out_ready), .out_data(o64_d), .flush(flush), .count(o64_c));

  pipe_skid_reg #(.DATA_W(8), .CLR_ON_FLUSH(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o8_ir), .in_data(in_data[7:0]),
    .out_valid(o8_v), .out_ready(out_ready), .out_data(o8_d), .flush(flush), .count(o8_c));

  pipe_skid_reg #(.DATA_W(8), .CLR_ON_FLUSH(1'b0)) u_dut8n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(on_ir), .in_data(in_data[7:0]),
    .out_valid(on_v), .out_ready(out_ready), .out_data(on_d), .flush(flush), .count(on_c));

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        orr;
    logic        fl;
    logic        ov;
    logic [63:0] od;
    logic [63:0] od_nc;
    logic [1:0]  cnt;
    logic        ir;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string tag, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h required %0h", tag, nm, act, exp);
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [63:0] od,
                           input logic [63:0] od_nc, input logic [1:0] cnt, input logic ir);
    chk(tag, "ov64", {63'b0, o64_v}, {63'b0, ov});
    chk(tag, "od64", o64_d, od);
    chk(tag, "cnt64", {62'b0, o64_c}, {62'b0, cnt});
    chk(tag, "ir64", {63'b0, o64_ir}, {63'b0, ir});
    chk(tag, "ov8", {63'b0, o8_v}, {63'b0, ov});
    chk(tag, "od8", {56'b0, o8_d}, {56'b0, od[7:0]});
    chk(tag, "cnt8", {62'b0, o8_c}, {62'b0, cnt});
    chk(tag, "ir8", {63'b0, o8_ir}, {63'b0, ir});
    chk(tag, "ovn", {63'b0, on_v}, {63'b0, ov});
    chk(tag, "odn", {56'b0, on_d}, {56'b0, od_nc[7:0]});
    chk(tag, "cntn", {62'b0, on_c}, {62'b0, cnt});
    chk(tag, "irn", {63'b0, on_ir}, {63'b0, ir});
  endtask

  task automatic step(input logic iv, input logic [63:0] d, input logic orr, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: queue of held payloads plus the last value shown on out_data
  logic [63:0] q[$];
  logic [63:0] disp;
  logic [63:0] disp_nc;

  task automatic model_edge(input logic iv, input logic [63:0] d, input logic orr, input logic fl);
    int pre_n;
    pre_n = q.size();
    if (fl) begin
      q.delete();
      disp = '0;
    end else begin
      if (pre_n > 0 && orr) void'(q.pop_front());
      if (iv && pre_n < 2)  q.push_back(d);
      if (q.size() > 0) begin
        disp    = q[0];
        disp_nc = q[0];
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 64'h11, 1'b1, 1'b0, 1'b1, 64'h11, 64'h11, 2'd1, 1'b1};
    tbl[1]  = '{1'b0, 64'h00, 1'b1, 1'b0, 1'b0, 64'h11, 64'h11, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 64'h0A, 1'b0, 1'b0, 1'b1, 64'h0A, 64'h0A, 2'd1, 1'b1};
    tbl[3]  = '{1'b1, 64'h0B, 1'b0, 1'b0, 1'b1, 64'h0A, 64'h0A, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 64'h0C, 1'b0, 1'b0, 1'b1, 64'h0A, 64'h0A, 2'd2, 1'b0};
    tbl[5]  = '{1'b1, 64'h0C, 1'b1, 1'b0, 1'b1, 64'h0B, 64'h0B, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 64'h0C, 1'b1, 1'b0, 1'b1, 64'h0C, 64'h0C, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 64'h00, 1'b1, 1'b0, 1'b0, 64'h0C, 64'h0C, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 64'h0A, 1'b0, 1'b0, 1'b1, 64'h0A, 64'h0A, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 64'h0B, 1'b0, 1'b0, 1'b1, 64'h0A, 64'h0A, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 64'h0D, 1'b0, 1'b1, 1'b0, 64'h00, 64'h0A, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 64'h00, 64'h0A, 2'd0, 1'b1};
    tbl[12] = '{1'b1, 64'h5A, 1'b1, 1'b0, 1'b1, 64'h5A, 64'h5A, 2'd1, 1'b1};
    tbl[13] = '{1'b0, 64'h00, 1'b1, 1'b1, 1'b0, 64'h00, 64'h5A, 2'd0, 1'b1};

    // Reset asserted before the first clock edge
    #1 rst = 1'b1;
    #2;
    check_all("reset", 1'b0, 64'h0, 64'h0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_reset", 1'b0, 64'h0, 64'h0, 2'd0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].orr, tbl[i].fl);
      check_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].od, tbl[i].od_nc, tbl[i].cnt, tbl[i].ir);
    end

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 64'(i), 1'b1, 1'b0);
      check_all($sformatf("stream%0d", i), 1'b1, 64'(i), 64'(i), 2'd1, 1'b1);
    end
    step(1'b0, 64'h0, 1'b1, 1'b0);
    check_all("stream_drain", 1'b0, 64'h8, 64'h8, 2'd0, 1'b1);

    // Asynchronous reset in the middle of a cycle while FULL
    step(1'b1, 64'h0A, 1'b0, 1'b0);
    step(1'b1, 64'h0B, 1'b0, 1'b0);
    check_all("full_pre_rst", 1'b1, 64'h0A, 64'h0A, 2'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 64'h0, 64'h0, 2'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    step(1'b1, 64'h5, 1'b0, 1'b0);
    check_all("push5", 1'b1, 64'h5, 64'h5, 2'd1, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    check_all("push5_alone", 1'b0, 64'h5, 64'h5, 2'd0, 1'b1);

    q.delete();
    disp    = 64'h5;
    disp_nc = 64'h5;
    for (int c = 0; c < 10000; c++) begin
      logic        iv, orr, fl;
      logic [63:0] d;
      iv  = ($urandom_range(0, 3) != 0);
      orr = (c % 2000 < 1000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 63) == 0);
      d   = {$urandom, $urandom};
      model_edge(iv, d, orr, fl);
      step(iv, d, orr, fl);
      check_all($sformatf("rand%0d", c), q.size() > 0, disp, disp_nc, 2'(q.size()), q.size() < 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
